trigger_out_sched: RTL and testbench

- Transmit-side scheduler for the serial trigger line.
- Collects event requests (SYN, TRG, RSR, RST) from up to four sources and arbitrates between them by fixed priority.
- Serialises each granted event as a 3-slot frame: start bit 1, then code[1], then code[0]. Each slot lasts one sync period.
- Output feeds the sync-strobed trigger input decoder.
- Codes: 00 = SYN, 01 = RST, 10 = TRG, 11 = RSR.

---
 rtl/trigger_out_sched.sv | 148 ++++++++++++++
 tb/tb_trigger_out_sched.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/trigger_out_sched.sv
// Transmit-side scheduler for the serial trigger line.
// Captures event requests from four sources, arbitrates them by fixed
// priority (RST > RSR > TRG > SYN) and serialises each grant as a 3-slot
// frame (start bit, code[1], code[0]), optionally followed by idle gap slots.
// Line activity only advances on clock edges where sync is high.
module trigger_out_sched #(
  parameter int GAP    = 0,
  parameter int LOST_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sync,
  input  logic              enable,
  input  logic [3:0]        req,
  input  logic              clear_lost,
  output logic              dout,
  output logic              busy,
  output logic [3:0]        pending,
  output logic [3:0]        sent,
  output logic [LOST_W-1:0] lost_cnt
);

  typedef enum logic [1:0] {IDLE, C1, C0, GAPS} state_t;

  localparam logic [3:0]        GAP_L    = 4'(GAP);
  localparam logic [LOST_W-1:0] LOST_MAX = '1;
  localparam logic [LOST_W-1:0] LOST_ONE = LOST_W'(1);

  state_t            state_q, state_d;
  logic [3:0]        gap_q, gap_d;
  logic [1:0]        code_q, code_d;
  logic              dout_q, dout_d;
  logic              busy_q;
  logic [3:0]        pending_q, pending_d;
  logic [3:0]        sent_q;
  logic [3:0]        grant;
  logic [3:0]        loss;
  logic [LOST_W-1:0] lost_q, lost_d;

  // Per-source capture: a request sets its flag; a grant clears it unless a
  // fresh request lands on the same edge. A request that finds its flag
  // already set and not being granted is dropped.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_capture
      assign pending_d[gi] = req[gi] | (pending_q[gi] & ~grant[gi]);
      assign loss[gi]      = req[gi] & pending_q[gi] & ~grant[gi];
    end
  endgenerate

  // Saturating count of cycles with at least one dropped request; clear wins.
  always_comb begin
    lost_d = lost_q;
    if (clear_lost) begin
      lost_d = '0;
    end else if ((|loss) && (lost_q != LOST_MAX)) begin
      lost_d = lost_q + LOST_ONE;
    end
  end

  // Frame sequencer next-state, line value and grant selection.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    code_d  = code_q;
    dout_d  = dout_q;
    grant   = 4'b0000;
    if (sync) begin
      case (state_q)
        IDLE: begin
          dout_d = 1'b0;
          if (enable && (pending_q != 4'b0000)) begin
            if (pending_q[3]) begin
              grant  = 4'b1000;
              code_d = 2'b01;
            end else if (pending_q[2]) begin
              grant  = 4'b0100;
              code_d = 2'b11;
            end else if (pending_q[1]) begin
              grant  = 4'b0010;
              code_d = 2'b10;
            end else begin
              grant  = 4'b0001;
              code_d = 2'b00;
            end
            dout_d  = 1'b1;
            state_d = C1;
          end
        end
        C1: begin
          dout_d  = code_q[1];
          state_d = C0;
        end
        C0: begin
          dout_d = code_q[0];
          if (GAP_L == 4'd0) begin
            state_d = IDLE;
          end else begin
            gap_d   = GAP_L;
            state_d = GAPS;
          end
        end
        GAPS: begin
          dout_d = 1'b0;
          if (gap_q <= 4'd1) begin
            gap_d   = 4'd0;
            state_d = IDLE;
          end else begin
            gap_d = gap_q - 4'd1;
          end
        end
        default: begin
          dout_d  = 1'b0;
          state_d = IDLE;
        end
      endcase
    end
  end

  // State, line and status registers; reset abandons any partial frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      gap_q     <= 4'd0;
      code_q    <= 2'b00;
      dout_q    <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= 4'b0000;
      sent_q    <= 4'b0000;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      gap_q     <= gap_d;
      code_q    <= code_d;
      dout_q    <= dout_d;
      busy_q    <= (state_d != IDLE);
      pending_q <= pending_d;
      sent_q    <= grant;
      lost_q    <= lost_d;
    end
  end

  assign dout     = dout_q;
  assign busy     = busy_q;
  assign pending  = pending_q;
  assign sent     = sent_q;
  assign lost_cnt = lost_q;

endmodule

// File: tb/tb_trigger_out_sched.sv
// Bench for trigger_out_sched: three instances (GAP=0, GAP=2, LOST_W=2)
// share one stimulus stream. A small line decoder watches the GAP=0 instance
// and checks each decoded event against a queue of expected codes.
module tb_trigger_out_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic       sync;
  logic       enable;
  logic [3:0] req;
  logic       clear_lost;

  logic       dout0, busy0;
  logic [3:0] pending0, sent0;
  logic [7:0] lost0;
  logic       dout2, busy2;
  logic [3:0] pending2, sent2;
  logic [7:0] lost2;
  logic       doutl, busyl;
  logic [3:0] pendingl, sentl;
  logic [1:0] lostl;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] C_SYN = 2'b00;
  localparam logic [1:0] C_RST = 2'b01;
  localparam logic [1:0] C_TRG = 2'b10;
  localparam logic [1:0] C_RSR = 2'b11;

  logic [1:0] exp_q[$];
  int         dec_st = 0;
  logic       dec_b1 = 1'b0;
  logic [1:0] dec_got, dec_want;

  trigger_out_sched #(.GAP(0), .LOST_W(8)) dut0 (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .req(req),
    .clear_lost(clear_lost), .dout(dout0), .busy(busy0), .pending(pending0),
    .sent(sent0), .lost_cnt(lost0));

  trigger_out_sched #(.GAP(2), .LOST_W(8)) dut2 (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .req(req),
    .clear_lost(clear_lost), .dout(dout2), .busy(busy2), .pending(pending2),
    .sent(sent2), .lost_cnt(lost2));

  trigger_out_sched #(.GAP(0), .LOST_W(2)) dutl (
    .clk(clk), .reset(reset), .sync(sync), .enable(enable), .req(req),
    .clear_lost(clear_lost), .dout(doutl), .busy(busyl), .pending(pendingl),
    .sent(sentl), .lost_cnt(lostl));

  always #5 clk = ~clk;

  // Reference decoder: samples the held line value just before each sync edge.
  always @(negedge clk) begin
    if (reset) begin
      dec_st = 0;
    end else if (sync) begin
      case (dec_st)
        0: if (dout0 === 1'b1) dec_st = 1;
        1: begin
          dec_b1 = dout0;
          dec_st = 2;
        end
        default: begin
          dec_got = {dec_b1, dout0};
          dec_st  = 0;
          n_checks++;
          if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL decode: got event code %b, required no event", dec_got);
          end else begin
            dec_want = exp_q.pop_front();
            if (dec_got !== dec_want) begin
              n_fail++;
              $display("FAIL decode: got event code %b, required %b", dec_got, dec_want);
            end else begin
              $display("decode: event code %b", dec_got);
            end
          end
        end
      endcase
    end
  end

  task automatic clk_cycle(input logic s);
    sync = s;
    @(posedge clk);
    #1;
  endtask

  // One slot: three quiet clocks then a sync edge.
  task automatic slot();
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b1);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    req = 4'b0000;
    enable = 1'b0;
    clear_lost = 1'b0;
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    reset = 1'b0;
    clk_cycle(1'b0);
  endtask

  task automatic wait_drain(input int max_slots);
    for (int k = 0; k < max_slots && exp_q.size() != 0; k++) slot();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d events still expected, required 0", exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; enable = 1'b1; req = 4'b1111; clear_lost = 1'b0;
    clk_cycle(1'b1);
    clk_cycle(1'b1);
    n_checks++;
    if ({dout0, busy0, pending0, sent0, lost0} !== 18'd0) begin
      n_fail++;
      $display("FAIL reset_hold: got dout=%b busy=%b pend=%b sent=%b lost=%0d, required all 0",
               dout0, busy0, pending0, sent0, lost0);
    end
    reset = 1'b0; req = 4'b0000; enable = 1'b0;
    clk_cycle(1'b0);
    n_checks++;
    if ({dout2, busy2, pending2, sent2, lost2, doutl, busyl, pendingl, sentl, lostl} !== 30'd0) begin
      n_fail++;
      $display("FAIL reset_release: got nonzero outputs on dut2/dutl, required all 0");
    end
    $display("reset: checked");
  endtask

  task automatic test_single_trg();
    logic [3:0] seq;
    apply_reset();
    enable = 1'b1;
    req = 4'b0010;
    clk_cycle(1'b0);
    req = 4'b0000;
    exp_q.push_back(C_TRG);
    n_checks++;
    if (pending0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL t1_capture: got pending %b, required 0010", pending0);
    end
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b1);
    n_checks++;
    if (sent0 !== 4'b0010 || dout0 !== 1'b1 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL t1_grant: got sent=%b dout=%b busy=%b, required 0010 1 1", sent0, dout0, busy0);
    end
    clk_cycle(1'b0);
    n_checks++;
    if (sent0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL t1_sent_pulse: got sent %b, required 0000", sent0);
    end
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    clk_cycle(1'b1);
    seq = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (dout0 !== seq[3-k]) begin
        n_fail++;
        $display("FAIL t1_dout slot %0d: got %b, required %b", k + 1, dout0, seq[3-k]);
      end
      if (k < 2) slot();
    end
    n_checks++;
    if (busy0 !== 1'b0 || pending0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL t1_idle: got busy=%b pending=%b, required 0 0000", busy0, pending0);
    end
    wait_drain(4);
  endtask

  task automatic test_all_four();
    logic [11:0] seq;
    logic [15:0] snt;
    logic [3:0]  want_sent;
    apply_reset();
    enable = 1'b1;
    req = 4'b1111;
    clk_cycle(1'b0);
    req = 4'b0000;
    exp_q.push_back(C_RST);
    exp_q.push_back(C_RSR);
    exp_q.push_back(C_TRG);
    exp_q.push_back(C_SYN);
    seq = 12'b101_111_110_100;
    snt = 16'b1000_0100_0010_0001;
    for (int k = 0; k < 12; k++) begin
      slot();
      n_checks++;
      if (dout0 !== seq[11-k]) begin
        n_fail++;
        $display("FAIL t2_dout slot %0d: got %b, required %b", k, dout0, seq[11-k]);
      end
      if (k % 3 == 0) begin
        want_sent = snt[15-(k/3)*4 -: 4];
        n_checks++;
        if (sent0 !== want_sent) begin
          n_fail++;
          $display("FAIL t2_sent slot %0d: got %b, required %b", k, sent0, want_sent);
        end
      end
    end
    slot();
    n_checks++;
    if (dout0 !== 1'b0 || lost0 !== 8'd0 || pending0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL t2_end: got dout=%b lost=%0d pending=%b, required 0 0 0000", dout0, lost0, pending0);
    end
    wait_drain(4);
  endtask

  task automatic test_gap();
    logic [9:0] seq;
    logic [9:0] bsy;
    apply_reset();
    enable = 1'b1;
    req = 4'b0011;
    clk_cycle(1'b0);
    req = 4'b0000;
    exp_q.push_back(C_TRG);
    exp_q.push_back(C_SYN);
    seq = 10'b11000_10000;
    bsy = 10'b11110_11110;
    for (int k = 0; k < 10; k++) begin
      slot();
      n_checks++;
      if (dout2 !== seq[9-k] || busy2 !== bsy[9-k]) begin
        n_fail++;
        $display("FAIL t3_gap slot %0d: got dout=%b busy=%b, required %b %b",
                 k, dout2, busy2, seq[9-k], bsy[9-k]);
      end
      if (k == 0 || k == 5) begin
        n_checks++;
        if (sent2 !== ((k == 0) ? 4'b0010 : 4'b0001)) begin
          n_fail++;
          $display("FAIL t3_sent slot %0d: got %b, required %b", k, sent2,
                   (k == 0) ? 4'b0010 : 4'b0001);
        end
      end
    end
    wait_drain(4);
  endtask

  task automatic test_loss();
    apply_reset();
    enable = 1'b0;
    req = 4'b0010;
    for (int k = 0; k < 3; k++) clk_cycle(1'b0);
    n_checks++;
    if (lost0 !== 8'd2 || lostl !== 2'd2 || pending0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL t4_loss: got lost0=%0d lostl=%0d pending=%b, required 2 2 0010", lost0, lostl, pending0);
    end
    for (int k = 0; k < 5; k++) clk_cycle(1'b0);
    n_checks++;
    if (lostl !== 2'd3 || lost0 !== 8'd7) begin
      n_fail++;
      $display("FAIL t4_saturate: got lostl=%0d lost0=%0d, required 3 7", lostl, lost0);
    end
    clear_lost = 1'b1;
    clk_cycle(1'b0);
    clear_lost = 1'b0;
    n_checks++;
    if (lostl !== 2'd0 || lost0 !== 8'd0) begin
      n_fail++;
      $display("FAIL t4_clear: got lostl=%0d lost0=%0d, required 0 0", lostl, lost0);
    end
    clk_cycle(1'b0);
    req = 4'b0000;
    n_checks++;
    if (lostl !== 2'd1) begin
      n_fail++;
      $display("FAIL t4_resume: got lostl=%0d, required 1", lostl);
    end
    slot();
    n_checks++;
    if (busy0 !== 1'b0 || sent0 !== 4'b0000 || pending0 !== 4'b0010) begin
      n_fail++;
      $display("FAIL t4_no_grant: got busy=%b sent=%b pending=%b, required 0 0000 0010", busy0, sent0, pending0);
    end
    $display("loss: checked");
  endtask

  task automatic test_collision();
    apply_reset();
    enable = 1'b1;
    req = 4'b0100;
    clk_cycle(1'b0);
    req = 4'b0000;
    exp_q.push_back(C_RSR);
    exp_q.push_back(C_RSR);
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    req = 4'b0100;
    clk_cycle(1'b1);
    req = 4'b0000;
    n_checks++;
    if (sent0 !== 4'b0100 || pending0 !== 4'b0100 || lost0 !== 8'd0 || dout0 !== 1'b1) begin
      n_fail++;
      $display("FAIL t5_collide: got sent=%b pending=%b lost=%0d dout=%b, required 0100 0100 0 1",
               sent0, pending0, lost0, dout0);
    end
    for (int k = 1; k < 6; k++) begin
      slot();
      n_checks++;
      if (dout0 !== 1'b1) begin
        n_fail++;
        $display("FAIL t5_dout slot %0d: got %b, required 1", k, dout0);
      end
      if (k == 3) begin
        n_checks++;
        if (sent0 !== 4'b0100 || pending0 !== 4'b0000) begin
          n_fail++;
          $display("FAIL t5_regrant: got sent=%b pending=%b, required 0100 0000", sent0, pending0);
        end
      end
    end
    slot();
    n_checks++;
    if (dout0 !== 1'b0 || lost0 !== 8'd0) begin
      n_fail++;
      $display("FAIL t5_end: got dout=%b lost=%0d, required 0 0", dout0, lost0);
    end
    wait_drain(4);
  endtask

  task automatic test_enable_and_reset();
    apply_reset();
    enable = 1'b1;
    req = 4'b0001;
    clk_cycle(1'b0);
    req = 4'b0000;
    exp_q.push_back(C_SYN);
    slot();
    n_checks++;
    if (sent0 !== 4'b0001 || dout0 !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_grant: got sent=%b dout=%b, required 0001 1", sent0, dout0);
    end
    enable = 1'b0;
    req = 4'b1000;
    clk_cycle(1'b0);
    req = 4'b0000;
    slot();
    slot();
    n_checks++;
    if (dout0 !== 1'b0 || pending0 !== 4'b1000) begin
      n_fail++;
      $display("FAIL t6_complete: got dout=%b pending=%b, required 0 1000", dout0, pending0);
    end
    slot();
    slot();
    n_checks++;
    if (busy0 !== 1'b0 || sent0 !== 4'b0000 || pending0 !== 4'b1000) begin
      n_fail++;
      $display("FAIL t6_hold: got busy=%b sent=%b pending=%b, required 0 0000 1000", busy0, sent0, pending0);
    end
    wait_drain(2);
    enable = 1'b1;
    exp_q.push_back(C_RST);
    slot();
    req = 4'b0101;
    clk_cycle(1'b0);
    req = 4'b0000;
    slot();
    slot();
    n_checks++;
    if (dout0 !== 1'b1) begin
      n_fail++;
      $display("FAIL t6_rst_c0: got dout=%b, required 1", dout0);
    end
    slot();
    slot();
    n_checks++;
    if (dout0 !== 1'b1 || busy0 !== 1'b1 || pending0 !== 4'b0001) begin
      n_fail++;
      $display("FAIL t6_mid_frame: got dout=%b busy=%b pending=%b, required 1 1 0001", dout0, busy0, pending0);
    end
    #2;
    reset = 1'b1;
    #1;
    n_checks++;
    if (dout0 !== 1'b0 || busy0 !== 1'b0 || pending0 !== 4'b0000 || sent0 !== 4'b0000) begin
      n_fail++;
      $display("FAIL t6_async_reset: got dout=%b busy=%b pending=%b sent=%b, required 0 0 0000 0000",
               dout0, busy0, pending0, sent0);
    end
    clk_cycle(1'b0);
    clk_cycle(1'b0);
    reset = 1'b0;
    slot();
    slot();
    n_checks++;
    if (dout0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL t6_after_reset: got dout=%b busy=%b, required 0 0", dout0, busy0);
    end
    wait_drain(2);
  endtask

  initial begin
    reset = 1'b1;
    sync = 1'b0;
    enable = 1'b0;
    req = 4'b0000;
    clear_lost = 1'b0;
    test_reset();
    test_single_trg();
    test_all_four();
    test_gap();
    test_loss();
    test_collision();
    test_enable_and_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
